mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Round-robin arbiter that shares one sequential multiplier (start/ready handshake, WIDTH-bit operands, 2*WIDTH-bit product) among NREQ requesters. It latches the winning requester's operands, issues the start pulse, waits for ready with a timeout guard, and returns the product with a per-requester done pulse. It sits between client blocks and a single multiplier instance such as the radix-4 or streamlined multiplier.

## Interface

- WIDTH, 8, operand width; product is 2*WIDTH
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 64, max cycles spent in WAIT before abort (≥ 4)

- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous, active-low reset
- req  in  NREQ  request level per requester; held until that requester's done
- ina_bus  in  NREQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- inb_bus  in  NREQ*WIDTH  operand B; same packing
- gnt  out  NREQ  one-hot; high for the granted requester from grant through the DONE cycle
- done  out  NREQ  one-cycle pulse to the served requester
- result  out  2*WIDTH  product of last completed op; held until next done
- timeout_err  out  1  one-cycle pulse, coincident with done, when an op aborted
- mul_a  out  WIDTH  operand A to multiplier
- mul_b  out  WIDTH  operand B to multiplier
- mul_start  out  1  one-cycle start pulse
- mul_out  in  2*WIDTH  multiplier product
- mul_ready  in  1  multiplier result valid

## Operation

- All outputs registered. Reset: state IDLE, rr pointer 0, wait counter 0, every output 0.
- States: IDLE, START, GUARD, WAIT, DONE.
- IDLE: if req != 0, winner = first set bit searching from pointer upward, wrapping at NREQ-1 → 0. Latch winner's operands into mul_a/mul_b, set gnt[winner], go START. If req == 0, stay.
- START: mul_start = 1 for exactly this cycle; go GUARD.
- GUARD: mul_start = 0; mul_ready ignored (may be stale from the previous op); clear counter; go WAIT.
- WAIT: if mul_ready, latch mul_out into result, go DONE. Otherwise counter++; on reaching TIMEOUT, set result = 0, flag abort, go DONE.
- DONE: done[winner] = 1 and timeout_err = abort for this cycle; pointer = (winner+1) mod NREQ; gnt cleared on exit; go IDLE.
- Operands are sampled only at the IDLE→START edge. Later changes on ina_bus/inb_bus, or dropping req, do not affect the op in flight. done still pulses for the granted requester.
- req still high in the cycle after DONE is treated as a new request. Because the pointer has advanced, other pending requesters win first.
- req bits for non-granted requesters are ignored outside IDLE.
- Products are unsigned; result width is exactly 2*WIDTH with no truncation. Signedness is the multiplier's concern; result is passed through unaltered.
- Asserting rstn low mid-operation immediately forces the reset state and values. No done is issued for the aborted op.

## Timing

- Req high before edge k with state IDLE: gnt and mul_a/mul_b valid after edge k. mul_start high during cycle k+1→k+2. GUARD cycle follows. WAIT begins after edge k+3.
- If mul_ready is first high in WAIT cycle w: result valid, done and gnt high for one cycle after edge w+1.
- Minimum turnaround is 5 cycles, from req-sampling edge to done-falling edge. The next grant can occur on the edge after DONE.
- Timeout: done/timeout_err assert TIMEOUT+1 cycles after entering WAIT.
- mul_start never asserts twice per op. It never asserts while state ≠ START.

## Test plan

- Single request: WIDTH=8, req=0001, A=13, B=11, multiplier ready after 4 cycles → one mul_start pulse, done=0001 once, result=143, timeout_err=0.
- All requesters simultaneously: req=1111, operands i*10+1 by (i+2), each req dropped on its done → grants in order 0,1,2,3; results 2, 33, 84, 155; one done per requester.
- Fairness: req0 held continuously, req2 raised mid-op of req0 → after req0's done, req2 granted next. The pointer wraps 3→0 correctly.
- Timeout: TIMEOUT=8, mul_ready tied 0 → done and timeout_err pulse together 9 cycles after WAIT entry, result=0, return to IDLE.
- Operand/req change mid-op: change A from 200 to 5 and drop req after grant, B=255 → result=51000, done still pulses.
- Reset mid-WAIT: pulse rstn low → all outputs 0 immediately, no done. A subsequent req=0100 is granted with the pointer restarted at 0.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one start/ready multiplier among NREQ requesters
module mult_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] ina_bus,
    input  logic [NREQ*WIDTH-1:0] inb_bus,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [2*WIDTH-1:0]    result,
    output logic                  timeout_err,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    output logic                  mul_start,
    input  logic [2*WIDTH-1:0]    mul_out,
    input  logic                  mul_ready
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, GUARD, WAIT, DONE} state_t;

    state_t               state, state_nx;
    logic [IW-1:0]        ptr, ptr_nx;
    logic [IW-1:0]        win, win_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [NREQ-1:0]      gnt_nx, done_nx;
    logic [2*WIDTH-1:0]   result_nx;
    logic                 terr_nx, start_nx;
    logic [WIDTH-1:0]     mul_a_nx, mul_b_nx;

    logic                 found;
    logic [IW-1:0]        pick;
    logic [IW:0]          cand;

    // first requester at or above the pointer, wrapping back to 0
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        win_nx    = win;
        cnt_nx    = cnt;
        gnt_nx    = gnt;
        done_nx   = '0;
        result_nx = result;
        terr_nx   = 1'b0;
        start_nx  = 1'b0;
        mul_a_nx  = mul_a;
        mul_b_nx  = mul_b;
        case (state)
            IDLE: begin
                if (found) begin
                    win_nx   = pick;
                    gnt_nx   = NREQ'(1) << pick;
                    mul_a_nx = ina_bus[pick*WIDTH +: WIDTH];
                    mul_b_nx = inb_bus[pick*WIDTH +: WIDTH];
                    cnt_nx   = '0;
                    state_nx = START;
                end
            end
            // two cycles: the registered start pulse is high during the second
            START: begin
                if (cnt == '0) begin
                    start_nx = 1'b1;
                    cnt_nx   = CW'(1);
                end else begin
                    cnt_nx   = '0;
                    state_nx = GUARD;
                end
            end
            GUARD: begin
                cnt_nx   = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                if (mul_ready) begin
                    result_nx = mul_out;
                    done_nx   = gnt;
                    state_nx  = DONE;
                end else if (cnt == CW'(TIMEOUT)) begin
                    result_nx = '0;
                    done_nx   = gnt;
                    terr_nx   = 1'b1;
                    state_nx  = DONE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            DONE: begin
                gnt_nx   = '0;
                ptr_nx   = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            ptr         <= '0;
            win         <= '0;
            cnt         <= '0;
            gnt         <= '0;
            done        <= '0;
            result      <= '0;
            timeout_err <= 1'b0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            win         <= win_nx;
            cnt         <= cnt_nx;
            gnt         <= gnt_nx;
            done        <= done_nx;
            result      <= result_nx;
            timeout_err <= terr_nx;
            mul_start   <= start_nx;
            mul_a       <= mul_a_nx;
            mul_b       <= mul_b_nx;
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed vector bench for mult_share_arbiter
module tb_mult_share_arbiter;
    localparam int W = 8;
    localparam int N = 4;
    localparam int T = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req;
    logic [N*W-1:0]  ina_bus, inb_bus;
    logic [N-1:0]    gnt, done;
    logic [2*W-1:0]  result;
    logic            timeout_err;
    logic [W-1:0]    mul_a, mul_b;
    logic            mul_start;
    logic [2*W-1:0]  mul_out;
    logic            mul_ready;

    mult_share_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(T)) dut (
        .clk(clk), .rstn(rstn), .req(req), .ina_bus(ina_bus), .inb_bus(inb_bus),
        .gnt(gnt), .done(done), .result(result), .timeout_err(timeout_err),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_out(mul_out), .mul_ready(mul_ready)
    );

    always #5 clk = ~clk;

    // multiplier model: reacts one edge after start, ready lat edges later; lat 0 = never ready
    int             lat;
    int             rem;
    logic           start_q;
    logic [2*W-1:0] prod;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_q   <= 1'b0;
            rem       <= 0;
            prod      <= '0;
            mul_ready <= 1'b0;
            mul_out   <= '0;
        end else begin
            start_q <= mul_start;
            if (start_q) begin
                prod      <= {8'b0, mul_a} * {8'b0, mul_b};
                rem       <= lat;
                mul_ready <= 1'b0;
            end else if (rem != 0) begin
                rem <= rem - 1;
                if (rem == 1) begin
                    mul_ready <= 1'b1;
                    mul_out   <= prod;
                end
            end
        end
    end

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        int         lat;
        logic [15:0] res;
        bit         to;
        bit         mangle;
    } vec_t;

    vec_t        tbl [6];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] prev_res;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_evt(input bit want_done, output logic [N-1:0] v);
        bit got;
        got = 1'b0;
        v   = '0;
        for (int i = 0; i < 100; i++) begin
            if (!got) begin
                @(negedge clk);
                if (want_done ? (done != 0) : (gnt != 0)) begin
                    got = 1'b1;
                    v   = want_done ? done : gnt;
                end
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_%s: no event within 100 cycles", want_done ? "done" : "gnt");
        end
    endtask

    task automatic do_op(input vec_t v);
        int s, ns, sat, exp_s;
        logic [N-1:0] oh;
        bit seen;
        oh    = N'(1) << v.idx;
        exp_s = (v.lat == 0) ? T + 5 : v.lat + 5;
        @(negedge clk);
        chk("idle_done_clear", done, 0);
        chk("idle_gnt_clear", gnt, 0);
        for (int i = 0; i < N; i++) begin
            ina_bus[i*W +: W] = W'($urandom);
            inb_bus[i*W +: W] = W'($urandom);
        end
        ina_bus[v.idx*W +: W] = v.a;
        inb_bus[v.idx*W +: W] = v.b;
        req = oh;
        lat = v.lat;
        s = 0; ns = 0; sat = 0; seen = 1'b0;
        while (!seen && s < 40) begin
            @(negedge clk);
            s++;
            if (s == 1) begin
                chk("grant", gnt, oh);
                chk("mul_a", mul_a, v.a);
                chk("mul_b", mul_b, v.b);
                chk("result_held", result, prev_res);
                if (v.mangle) begin
                    ina_bus[v.idx*W +: W] = 8'd5;
                    req = '0;
                end
            end
            if (mul_start) begin
                ns++;
                sat = s;
            end
            if (done != 0) begin
                seen = 1'b1;
                chk("done", done, oh);
                chk("gnt_at_done", gnt, oh);
                chk("result", result, v.res);
                chk("timeout_err", timeout_err, v.to);
                chk("done_latency", s, exp_s);
                req = '0;
            end
        end
        if (!seen) chk("done_seen", 0, 1);
        chk("start_count", ns, 1);
        chk("start_cycle", sat, 2);
        prev_res = v.res;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] v;
        logic [15:0]  all_exp [4];
        all_exp = '{16'd2, 16'd33, 16'd84, 16'd155};

        tbl[0] = '{0, 8'd13,  8'd11,  4, 16'd143,   1'b0, 1'b0};
        tbl[1] = '{2, 8'd255, 8'd255, 2, 16'd65025, 1'b0, 1'b0};
        tbl[2] = '{3, 8'd0,   8'd77,  1, 16'd0,     1'b0, 1'b0};
        tbl[3] = '{0, 8'd200, 8'd255, 3, 16'd51000, 1'b0, 1'b1};
        tbl[4] = '{2, 8'd9,   8'd7,   0, 16'd0,     1'b1, 1'b0};
        tbl[5] = '{1, 8'd16,  8'd16,  5, 16'd256,   1'b0, 1'b0};

        rstn = 1'b0; req = '0; ina_bus = '0; inb_bus = '0; lat = 4;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_start", mul_start, 0);
        chk("rst_mul_ab", {mul_a, mul_b}, 0);
        rstn = 1'b1;

        // all requesters at once, each dropped on its done
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            ina_bus[i*W +: W] = W'(i*10 + 1);
            inb_bus[i*W +: W] = W'(i + 2);
        end
        lat = 3;
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            wait_evt(1'b1, v);
            chk("all_done_order", v, N'(1) << i);
            chk("all_result", result, all_exp[i]);
            req[i] = 1'b0;
        end

        // fairness and pointer wrap, from a fresh pointer
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < N; i++) begin
            ina_bus[i*W +: W] = 8'd3;
            inb_bus[i*W +: W] = 8'd3;
        end
        req = 4'b0001;
        wait_evt(1'b0, v); chk("fair_g0", v, 4'b0001);
        req[2] = 1'b1;
        wait_evt(1'b1, v); chk("fair_d0", v, 4'b0001);
        wait_evt(1'b0, v); chk("fair_g2", v, 4'b0100);
        req[3] = 1'b1;
        wait_evt(1'b1, v); chk("fair_d2", v, 4'b0100);
        req[2] = 1'b0;
        wait_evt(1'b0, v); chk("fair_g3", v, 4'b1000);
        req[1] = 1'b1;
        wait_evt(1'b1, v); chk("fair_d3", v, 4'b1000);
        req[3] = 1'b0;
        wait_evt(1'b0, v); chk("fair_wrap_g0", v, 4'b0001);
        wait_evt(1'b1, v); chk("fair_wrap_d0", v, 4'b0001);
        chk("fair_result", result, 9);
        req = '0;
        prev_res = 16'd9;

        for (int i = 0; i < 6; i++)
            do_op(tbl[i]);

        // reset in the middle of WAIT; pointer was 2 before it
        @(negedge clk);
        ina_bus[1*W +: W] = 8'd99;
        inb_bus[1*W +: W] = 8'd2;
        lat = 0;
        req = 4'b0010;
        repeat (6) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_result", result, 0);
        chk("midrst_mul_ab", {mul_a, mul_b}, 0);
        chk("midrst_start_terr", {mul_start, timeout_err}, 0);
        req = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
        end
        rstn = 1'b1;
        @(negedge clk);
        ina_bus[1*W +: W] = 8'd6;  inb_bus[1*W +: W] = 8'd7;
        ina_bus[2*W +: W] = 8'd12; inb_bus[2*W +: W] = 8'd12;
        lat = 2;
        req = 4'b0110;
        wait_evt(1'b0, v); chk("postrst_g1", v, 4'b0010);
        wait_evt(1'b1, v); chk("postrst_d1", v, 4'b0010);
        chk("postrst_r1", result, 42);
        req[1] = 1'b0;
        wait_evt(1'b0, v); chk("postrst_g2", v, 4'b0100);
        wait_evt(1'b1, v); chk("postrst_d2", v, 4'b0100);
        chk("postrst_r2", result, 144);
        req = '0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
